// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 reaction timer.
//   Contents: FSM state enum, light-bus patterns, BCD digit type and saturation value.
//   No logic; imported by the counter and the top.
package f1_pkg;

  typedef enum logic [2:0] {
    RT_IDLE,
    RT_ARMED,
    RT_TIMING,
    RT_DONE,
    RT_FALSE
  } rt_state_t;

  localparam logic [7:0] LIGHTS_ALL_ON = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF    = 8'h00;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  BCD_DIGIT_MAX = 4'd9;
  localparam logic [15:0] BCD_MAX       = 16'h9999;

endpackage

// File: rtl/f1_reaction_timer_if.sv
// Light-bus / button / display bundle between the start-light sequencer side and the timer.
//   master: drives lights and btn, observes the result.  slave: the timer itself.
//   Plain level signals; no handshake, nothing is ever backpressured.
interface f1_reaction_timer_if;
  logic [7:0]  lights;        // thermometer-coded start lights
  logic        btn;           // asynchronous driver button, active-high
  logic [15:0] bcd;           // reaction time, 4 BCD digits
  logic        result_valid;  // bcd holds a completed measurement
  logic        false_start;   // button pressed before lights out
  logic        timeout;       // 9999 ms reached without a press
  logic        timing;        // counter running

  modport master (
    output lights, btn,
    input  bcd, result_valid, false_start, timeout, timing
  );

  modport slave (
    input  lights, btn,
    output bcd, result_valid, false_start, timeout, timing
  );
endinterface

// File: rtl/bcd_counter4.sv
// Four-digit cascaded BCD counter (0000-9999) that saturates at 9999.
//   Ports: clk, rst (sync, active-low), clr, inc, q[15:0] (thousands in [15:12]), at_max.
//   q updates one cycle after clr/inc; clr beats inc; inc at 9999 holds 9999.
module bcd_counter4
  import f1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        at_max
);

  logic [15:0] q_q, q_d;
  logic        carry;
  bcd_digit_t  digit;

  assign at_max = (q_q == BCD_MAX);
  assign q      = q_q;

  // Ripple the increment up through the digits; a digit at 9 rolls to 0
  // and passes the carry on. Saturation blocks the carry at 9999.
  always_comb begin
    q_d   = q_q;
    carry = inc && !at_max;
    digit = '0;
    for (int i = 0; i < 4; i++) begin
      digit = q_q[i*4 +: 4];
      if (carry) begin
        if (digit == BCD_DIGIT_MAX) begin
          q_d[i*4 +: 4] = '0;
        end else begin
          q_d[i*4 +: 4] = digit + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    if (clr) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/f1_reaction_timer.sv
// Measures driver reaction in ms from lights-out to button press; flags jump starts and timeouts.
//   Ports: clk, rst (sync, active-low), bus (slave modport: lights/btn in, bcd + status flags out).
//   Press acts SYNC_STAGES+1 edges after btn is first sampled high; outputs are registered, never backpressured.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int unsigned CLK_PER_MS  = 48000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  f1_reaction_timer_if.slave bus
);

  localparam int unsigned PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_MS - 1);

  rt_state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    btn_prev_q;
  logic [7:0]              lights_q;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    rv_q, rv_d;
  logic                    fs_q, fs_d;
  logic                    to_q, to_d;

  logic                    press;
  logic                    lights_out;
  logic                    tick;
  logic                    cnt_clr, cnt_inc;
  logic [15:0]             cnt_q;
  logic                    cnt_at_max;

  // Rising edge of the synchronised button is a single-cycle press.
  assign press      = sync_q[SYNC_STAGES-1] && !btn_prev_q;
  assign lights_out = (lights_q == LIGHTS_ALL_ON) && (bus.lights == LIGHTS_OFF);
  assign tick       = (state_q == RT_TIMING) && (presc_q == PRESC_LAST);

  bcd_counter4 u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .q      (cnt_q),
    .at_max (cnt_at_max)
  );

  always_comb begin
    state_d = state_q;
    rv_d    = rv_q;
    fs_d    = fs_q;
    to_d    = to_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    // Prescaler only runs in TIMING, so it is always 0 on TIMING entry.
    presc_d = '0;
    if (state_q == RT_TIMING) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    end

    unique case (state_q)
      RT_IDLE: begin
        if (bus.lights != LIGHTS_OFF) begin
          state_d = RT_ARMED;
          cnt_clr = 1'b1;
          rv_d    = 1'b0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      RT_ARMED: begin
        // A press in the lights-out cycle still counts as a jump.
        if (press) begin
          state_d = RT_FALSE;
          fs_d    = 1'b1;
          cnt_clr = 1'b1;
        end else if (lights_out) begin
          state_d = RT_TIMING;
          cnt_clr = 1'b1;
        end else if (bus.lights == LIGHTS_OFF) begin
          state_d = RT_IDLE;
        end
      end
      RT_TIMING: begin
        // A tick coinciding with the press is not counted: only whole ms elapsed.
        if (press) begin
          state_d = RT_DONE;
          rv_d    = 1'b1;
        end else if (tick) begin
          if (cnt_at_max) begin
            state_d = RT_DONE;
            to_d    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      RT_DONE, RT_FALSE: begin
        if (bus.lights != LIGHTS_OFF) begin
          state_d = RT_ARMED;
          cnt_clr = 1'b1;
          rv_d    = 1'b0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: begin
        state_d = RT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RT_IDLE;
      sync_q     <= '0;
      btn_prev_q <= 1'b0;
      lights_q   <= '0;
      presc_q    <= '0;
      rv_q       <= 1'b0;
      fs_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.btn};
      btn_prev_q <= sync_q[SYNC_STAGES-1];
      lights_q   <= bus.lights;
      presc_q    <= presc_d;
      rv_q       <= rv_d;
      fs_q       <= fs_d;
      to_q       <= to_d;
    end
  end

  assign bus.bcd          = cnt_q;
  assign bus.result_valid = rv_q;
  assign bus.false_start  = fs_q;
  assign bus.timeout      = to_q;
  assign bus.timing       = (state_q == RT_TIMING);

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Self-checking bench for f1_reaction_timer with CLK_PER_MS=4, SYNC_STAGES=2.
//   Inputs driven and outputs sampled on the falling edge; expectations come from
//   elapsed-cycle arithmetic (reaction = whole ms in TIMING before the press).
module tb_f1_reaction_timer;

  localparam int CPM = 4;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   j       = 0;
  int   tlen    = 0;

  f1_reaction_timer_if bus ();

  f1_reaction_timer #(
    .CLK_PER_MS  (CPM),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int t;
    t = (v > 9999) ? 9999 : v;
    return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  function automatic logic [7:0] therm(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  // Cycle j of TIMING (j=0 first cycle) must show floor(j/CPM) ms.
  always @(negedge clk) begin
    if (bus.timing) begin
      check_eq("mon_bcd", 32'(bus.bcd), 32'(to_bcd(j / CPM)));
      j++;
      tlen = j;
    end else begin
      j = 0;
    end
  end

  task automatic check_outs(input string tag, input logic [15:0] bcd, input logic rv,
                            input logic fs, input logic to, input logic tm);
    check_eq({tag, "_bcd"}, 32'(bus.bcd), 32'(bcd));
    check_eq({tag, "_rv"}, 32'(bus.result_valid), 32'(rv));
    check_eq({tag, "_fs"}, 32'(bus.false_start), 32'(fs));
    check_eq({tag, "_to"}, 32'(bus.timeout), 32'(to));
    check_eq({tag, "_tm"}, 32'(bus.timing), 32'(tm));
  endtask

  task automatic release_btn();
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Lights count up 01..FF with random dwell; returns with FF held at least one cycle.
  task automatic ramp();
    for (int i = 1; i <= 8; i++) begin
      bus.lights = therm(i);
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
  endtask

  // Button goes high d cycles after lights out (d=-1: one cycle before).
  // The press then lands in TIMING cycle k=d+1, so bcd = k/CPM and TIMING lasts k+1 cycles.
  task automatic normal_run(input string tag, input int d);
    int k;
    ramp();
    if (d < 0) begin
      bus.btn = 1'b1;
      @(negedge clk);
      bus.lights = 8'h00;
      repeat (2) @(negedge clk);
    end else begin
      bus.lights = 8'h00;
      repeat (d) @(negedge clk);
      bus.btn = 1'b1;
      repeat (3) @(negedge clk);
    end
    k = d + 1;
    check_outs(tag, to_bcd(k / CPM), 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq({tag, "_len"}, 32'(tlen), 32'(k + 1));
    release_btn();
  endtask

  task automatic jump_run(input string tag, input int stage);
    for (int i = 1; i < stage; i++) begin
      bus.lights = therm(i);
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    bus.lights = therm(stage);
    bus.btn    = 1'b1;
    repeat (3) @(negedge clk);
    check_outs(tag, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    // Sequencer abandons the start; later presses must not disturb the verdict.
    bus.lights = 8'h00;
    repeat (2) @(negedge clk);
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    check_outs({tag, "_hold"}, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    release_btn();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d;
    int  seen;
    int  found;
    int  pulsed;
    int  dl[4] = '{-1, 2, 3, 39};

    rst        = 1'b0;
    bus.lights = 8'h00;
    bus.btn    = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Jump starts at a fixed and a random ramp stage.
    jump_run("jump1F", 5);
    jump_run("jumpR", int'($urandom_range(8, 1)));

    // Press coincident with lights out.
    ramp();
    bus.btn = 1'b1;
    repeat (2) @(negedge clk);
    bus.lights = 8'h00;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.timing) seen++;
    end
    check_eq("same_tm_seen", 32'(seen), 32'd0);
    check_outs("same", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    release_btn();

    // Normal runs: boundary offsets, then random reaction times.
    foreach (dl[i]) normal_run($sformatf("norm%0d", dl[i]), dl[i]);
    for (int r = 0; r < 5; r++) begin
      d = int'($urandom_range(150, 0));
      normal_run($sformatf("rand%0d", d), d);
    end

    // Re-arm from DONE with bcd 0010, then a second full run measuring 7 ms.
    normal_run("pre_rearm", 39);
    bus.lights = 8'h01;
    @(negedge clk);
    check_outs("rearm", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    normal_run("rearm_run", 27 + int'($urandom_range(3, 0)));

    // Timeout with carry checkpoints (iteration i is TIMING cycle i-1).
    ramp();
    bus.lights = 8'h00;
    found = 0;
    for (int i = 1; i <= 41000 && found == 0; i++) begin
      @(negedge clk);
      if (i == 40)  check_eq("carry_0009", 32'(bus.bcd), 32'h0009);
      if (i == 41)  check_eq("carry_0010", 32'(bus.bcd), 32'h0010);
      if (i == 400) check_eq("carry_0099", 32'(bus.bcd), 32'h0099);
      if (i == 401) check_eq("carry_0100", 32'(bus.bcd), 32'h0100);
      if (bus.timeout) found = i;
    end
    check_eq("to_cycle", 32'(found), 32'd40001);
    check_outs("timeout", 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("to_len", 32'(tlen), 32'd40000);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    check_outs("to_hold", 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0);
    release_btn();

    // Reset in the middle of TIMING; a between-edge rst glitch must be ignored.
    ramp();
    bus.lights = 8'h00;
    found  = 0;
    pulsed = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (bus.bcd == 16'h0050 && pulsed == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        pulsed = 1;
      end
      if (bus.bcd == 16'h0123) found = 1;
    end
    check_eq("rst_reach", 32'(found), 32'd1);
    check_eq("rst_glitch_tm", 32'(bus.timing), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_outs("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    // Back in IDLE: a press there is not a jump.
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    check_outs("idle_press", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    release_btn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
